// File: rtl/mt_pkg.sv
// -----------------------------------------------------------------------------
// mt_pkg
// Shared types and constants for the mt_cpu thread scheduler.
//   thread_state_t   : per-thread run state (IDLE / READY / INFLIGHT)
//   DEFAULT_RESET_PC : PC loaded into every thread at reset
//   tid_width()      : thread-id width for a given thread count
// -----------------------------------------------------------------------------
package mt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2
  } thread_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Smallest width able to index n threads; never below one bit.
  function automatic int tid_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage : mt_pkg

// File: rtl/mt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mt_rr_arbiter
// Purely combinational round-robin picker. The search starts one past the
// last grant and wraps, so the most recently served requester gets lowest
// priority.
//   i_req         : request mask, one bit per thread
//   i_last        : tid granted most recently
//   o_grant_valid : at least one request present
//   o_grant_tid   : chosen tid (0 when nothing requests)
// -----------------------------------------------------------------------------
module mt_rr_arbiter
  import mt_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int TID_WIDTH   = tid_width(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] i_req,
  input  logic [TID_WIDTH-1:0]   i_last,
  output logic                   o_grant_valid,
  output logic [TID_WIDTH-1:0]   o_grant_tid
);

  // Walk pointer+1 .. pointer+NUM_THREADS; the TID_WIDTH-bit add wraps
  // naturally because NUM_THREADS is a power of two.
  always_comb begin : p_pick
    logic [TID_WIDTH-1:0] w_idx;
    logic                 w_found;
    w_found       = 1'b0;
    o_grant_tid   = {TID_WIDTH{1'b0}};
    o_grant_valid = |i_req;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      w_idx = i_last + TID_WIDTH'(k);
      if (!w_found && i_req[w_idx]) begin
        o_grant_tid = w_idx;
        w_found     = 1'b1;
      end else begin
        w_found     = w_found;
      end
    end
  end

endmodule : mt_rr_arbiter

// File: rtl/mt_thread_scheduler.sv
// -----------------------------------------------------------------------------
// mt_thread_scheduler
// Per-thread run state and PC tracking for the mt_cpu barrel core. Each cycle
// one READY thread is offered to fetch in round-robin order; a thread stays
// INFLIGHT until writeback returns its next PC, so it never has two
// instructions in the pipe.
//   i_clk, i_rst (async, active-low)
//   i_start_valid/i_start_tid/i_start_pc : launch an IDLE thread
//   i_stall                              : freeze issue
//   o_issue_valid/o_issue_tid/o_issue_pc : thread presented to fetch
//   i_wb_valid/i_wb_tid/i_wb_next_pc/i_wb_halt : retire an in-flight slot
//   o_thread_active, o_all_halted        : run-state summary
//   o_protocol_err                       : sticky, wb to a non-INFLIGHT thread
// -----------------------------------------------------------------------------
module mt_thread_scheduler
  import mt_pkg::*;
#(
  parameter int                       NUM_THREADS   = 4,
  parameter int                       TID_WIDTH     = tid_width(NUM_THREADS),
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [NUM_THREADS-1:0]   RESET_MASK    = {NUM_THREADS{1'b1}}
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start_valid,
  input  logic [TID_WIDTH-1:0]     i_start_tid,
  input  logic [ADDRESS_WIDTH-1:0] i_start_pc,
  input  logic                     i_stall,
  output logic                     o_issue_valid,
  output logic [TID_WIDTH-1:0]     o_issue_tid,
  output logic [ADDRESS_WIDTH-1:0] o_issue_pc,
  input  logic                     i_wb_valid,
  input  logic [TID_WIDTH-1:0]     i_wb_tid,
  input  logic [ADDRESS_WIDTH-1:0] i_wb_next_pc,
  input  logic                     i_wb_halt,
  output logic [NUM_THREADS-1:0]   o_thread_active,
  output logic                     o_all_halted,
  output logic                     o_protocol_err
);

  thread_state_t              r_state     [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0]   r_pc        [NUM_THREADS];
  logic [TID_WIDTH-1:0]       r_ptr;
  logic                       r_perr;

  thread_state_t              w_state_nxt [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0]   w_pc_nxt    [NUM_THREADS];
  logic [TID_WIDTH-1:0]       w_ptr_nxt;
  logic                       w_perr_nxt;

  logic [NUM_THREADS-1:0]     w_ready;
  logic [NUM_THREADS-1:0]     w_hit_issue;
  logic [NUM_THREADS-1:0]     w_hit_wb;
  logic [NUM_THREADS-1:0]     w_hit_start;
  logic                       w_grant_valid;
  logic [TID_WIDTH-1:0]       w_grant_tid;
  logic                       w_fire;

  mt_rr_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .TID_WIDTH   (TID_WIDTH)
  ) u_arb (
    .i_req         (w_ready),
    .i_last        (r_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_tid   (w_grant_tid)
  );

  // Ready mask for the arbiter and the per-thread activity summary.
  always_comb begin
    w_ready         = {NUM_THREADS{1'b0}};
    o_thread_active = {NUM_THREADS{1'b0}};
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_ready[t]         = (r_state[t] == READY);
      o_thread_active[t] = (r_state[t] != IDLE);
    end
    o_all_halted = ~|o_thread_active;
  end

  // Next state: issue, writeback and start can only hit a given thread in
  // mutually exclusive states, so a priority chain per thread is exact.
  always_comb begin
    w_fire     = w_grant_valid & ~i_stall;
    w_ptr_nxt  = r_ptr;
    w_perr_nxt = r_perr;
    if (w_fire) begin
      w_ptr_nxt = w_grant_tid;
    end else begin
      w_ptr_nxt = r_ptr;
    end
    // A retire for a thread with nothing in the pipe is a protocol violation.
    if (i_wb_valid && (r_state[i_wb_tid] != INFLIGHT)) begin
      w_perr_nxt = 1'b1;
    end else begin
      w_perr_nxt = r_perr;
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_hit_issue[t] = w_fire && (w_grant_tid == TID_WIDTH'(t));
      w_hit_wb[t]    = i_wb_valid && (i_wb_tid == TID_WIDTH'(t)) && (r_state[t] == INFLIGHT);
      w_hit_start[t] = i_start_valid && (i_start_tid == TID_WIDTH'(t)) && (r_state[t] == IDLE);
      if (w_hit_wb[t]) begin
        w_pc_nxt[t]    = i_wb_next_pc;
        w_state_nxt[t] = i_wb_halt ? IDLE : READY;
      end else if (w_hit_start[t]) begin
        w_pc_nxt[t]    = i_start_pc;
        w_state_nxt[t] = READY;
      end else if (w_hit_issue[t]) begin
        w_pc_nxt[t]    = r_pc[t];
        w_state_nxt[t] = INFLIGHT;
      end else begin
        w_pc_nxt[t]    = r_pc[t];
        w_state_nxt[t] = r_state[t];
      end
    end
  end

  // State register; pointer resets to the last tid so tid 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_state[t] <= RESET_MASK[t] ? READY : IDLE;
        r_pc[t]    <= RESET_PC;
      end
      r_ptr  <= TID_WIDTH'(NUM_THREADS - 1);
      r_perr <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_state[t] <= w_state_nxt[t];
        r_pc[t]    <= w_pc_nxt[t];
      end
      r_ptr  <= w_ptr_nxt;
      r_perr <= w_perr_nxt;
    end
  end

  // Issue outputs; PC forced to zero when no thread is presented.
  always_comb begin
    o_issue_valid  = w_grant_valid;
    o_issue_tid    = w_grant_tid;
    o_protocol_err = r_perr;
    if (w_grant_valid) begin
      o_issue_pc = r_pc[w_grant_tid];
    end else begin
      o_issue_pc = {ADDRESS_WIDTH{1'b0}};
    end
  end

endmodule : mt_thread_scheduler

// File: doc/mt_thread_scheduler.md
Name: mt_thread_scheduler

Overview:
Thread scheduler for the barrel-processor core mt_cpu.
- Tracks per-thread run state and PC for NUM_THREADS hardware threads.
- Picks one ready thread per cycle in round-robin order and presents its tid and PC to fetch.
- Retires a thread's in-flight slot when writeback returns its next PC, so a thread never has two instructions in the pipe.
- Sits between the fetch stage and writeback, replacing the fixed modulo thread counter.

Parameters:
- NUM_THREADS, 4, number of hardware threads (power of two, >=2).
- TID_WIDTH, 2, thread-id width, equals log2(NUM_THREADS).
- ADDRESS_WIDTH, 32, PC width.
- RESET_PC, 32'h0, PC loaded into every thread at reset.
- RESET_MASK, 4'b1111, threads that are READY at reset; all others are IDLE.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_valid  in  1  launch request for an IDLE thread
- start_tid  in  TID_WIDTH  thread to launch
- start_pc  in  ADDRESS_WIDTH  launch PC
- stall  in  1  pipeline freeze (e.g. dmem busy); no issue while high
- issue_valid  out  1  a READY thread is presented
- issue_tid  out  TID_WIDTH  selected thread
- issue_pc  out  ADDRESS_WIDTH  PC of selected thread
- wb_valid  in  1  writeback retiring one instruction
- wb_tid  in  TID_WIDTH  thread being retired
- wb_next_pc  in  ADDRESS_WIDTH  resolved next PC (pc+4 or branch/jump target)
- wb_halt  in  1  retired instruction halts its thread (ecall/ebreak)
- thread_active  out  NUM_THREADS  bit i set when thread i is not IDLE
- all_halted  out  1  every thread IDLE
- protocol_err  out  1  sticky; set on an illegal wb

Behaviour:
- Thread state per thread: IDLE, READY, INFLIGHT. Each thread also has a PC register.
- Reset (rst low, async):
  - Threads in RESET_MASK go to READY with PC = RESET_PC; all others go to IDLE with PC = RESET_PC.
  - RR pointer = NUM_THREADS-1, so tid 0 is checked first.
  - protocol_err = 0.
- Reset outputs with default params: issue_valid=1, issue_tid=0, issue_pc=RESET_PC, thread_active=4'b1111, all_halted=0.
- Issue outputs are combinational from registered state:
  - Search starts at pointer+1, wraps modulo NUM_THREADS, and takes the first READY thread.
  - issue_valid=0 when no thread is READY; issue_tid/issue_pc are then 0.
- Issue fires when issue_valid && !stall. At the next edge the chosen thread goes READY->INFLIGHT and pointer = issue_tid.
- Stall: no state or pointer change, so issue_tid and issue_pc stay stable until stall drops.
- Writeback, when wb_valid and thread wb_tid is INFLIGHT:
  - PC <= wb_next_pc.
  - State -> IDLE if wb_halt, else READY.
  - Takes effect one cycle later, so the thread can issue again the cycle after wb at the earliest.
- Writeback with wb_valid to a thread not INFLIGHT: ignored, and protocol_err set until reset.
- Start, when start_valid and start_tid is IDLE: PC <= start_pc, state -> READY. Start to a non-IDLE thread is ignored (no error).
- Simultaneous events:
  - Issue, wb and start in one cycle always target threads in different states, so all three apply independently.
  - wb_valid is honoured during stall; start is honoured during stall.
- thread_active and all_halted are combinational from state (all_halted = ~|thread_active).
- Reset asserted mid-operation discards all in-flight state; in-flight writebacks arriving after reset release are flagged as protocol_err.

Decomposition:
- Package mt_pkg holds:
  - thread_state_t enum (IDLE=2'd0, READY=2'd1, INFLIGHT=2'd2)
  - TID_WIDTH derivation function
  - RESET_PC default
- One sub-module, mt_rr_arbiter: a NUM_THREADS-wide round-robin picker.
  - Inputs: req mask and last-grant pointer.
  - Outputs: grant_valid and grant_tid.
  - Purely combinational; the pointer register stays in the scheduler.

Test Plan:
- Reset with defaults, stall=0, wb returns each tid with pc+4 exactly one cycle after issue → issue_tid sequence 0,1,2,3,0,1…; each thread's issue_pc advances 0, 4, 8.
- Hold stall high 3 cycles while tid 2 is presented → issue_tid=2 and issue_pc constant for 3 cycles; tid 2 state unchanged; after release tid 2 issues once, then tid 3.
- Only tid 1 READY, its wb delayed 2 cycles → issue_valid=0 for those cycles; tid 1 reissues at wb_next_pc=32'h100 the cycle after wb.
- wb_halt for tids 0..3 in turn → thread_active steps 1110,1100,1000,0000; all_halted=1; start tid 3 pc 32'h80 → issue_tid=3, issue_pc=32'h80 next cycle.
- wb_valid for an IDLE tid → protocol_err=1 and sticky; no state change; start to a READY thread is ignored.
- Assert rst low mid-run asynchronously (between edges) → outputs immediately return to reset values (issue_tid=0, issue_pc=0).
